// File: rtl/nvme_doorbell_cq_ctrl.sv
// NVMe doorbell sequencer and CQ consumer. SQ-tail and CQ-head doorbells share one
// AXI-Lite write channel via round-robin; CQ entries are phase-checked and forwarded.
module nvme_doorbell_cq_ctrl #(
   parameter int          OUTSTANDING   = 16,
   parameter int          NL_ADDR_WIDTH = 32,
   parameter int          NL_DATA_WIDTH = 32,
   parameter logic [31:0] SQ_DB_ADDR    = 32'h0000_1000,
   parameter logic [31:0] CQ_DB_ADDR    = 32'h0000_1004
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [$clog2(OUTSTANDING)-1:0]   sq_tail,
   input  logic                             cqe_valid,
   output logic                             cqe_ready,
   input  logic [127:0]                     cqe_data,
   output logic [$clog2(OUTSTANDING)-1:0]   sq_head,
   output logic                             cpl_valid,
   input  logic                             cpl_ready,
   output logic [15:0]                      cpl_cid,
   output logic [14:0]                      cpl_status,
   output logic [NL_ADDR_WIDTH-1:0]         nl_awaddr,
   output logic                             nl_awvalid,
   input  logic                             nl_awready,
   output logic [NL_DATA_WIDTH-1:0]         nl_wdata,
   output logic [NL_DATA_WIDTH/8-1:0]       nl_wstrb,
   output logic                             nl_wvalid,
   input  logic                             nl_wready,
   input  logic [1:0]                       nl_bresp,
   input  logic                             nl_bvalid,
   output logic                             nl_bready,
   output logic                             db_err
);

   localparam int PW = $clog2(OUTSTANDING);
   localparam logic [NL_ADDR_WIDTH-1:0] SQ_ADDR = NL_ADDR_WIDTH'(SQ_DB_ADDR);
   localparam logic [NL_ADDR_WIDTH-1:0] CQ_ADDR = NL_ADDR_WIDTH'(CQ_DB_ADDR);
   localparam logic [PW-1:0] HEAD_LAST = PW'(OUTSTANDING - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_B} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [PW-1:0]            r_rung_tail;
   logic [PW-1:0]            r_cq_head;
   logic [PW-1:0]            r_sq_head;
   logic                     r_exp_phase;
   logic                     r_cq_pending;
   logic                     r_last_grant_cq;
   logic                     r_awvalid;
   logic                     r_wvalid;
   logic [NL_ADDR_WIDTH-1:0] r_awaddr;
   logic [NL_DATA_WIDTH-1:0] r_wdata;
   logic                     r_db_err;
   logic                     r_cpl_valid;
   logic [15:0]              r_cpl_cid;
   logic [14:0]              r_cpl_status;

   logic                     w_sq_pend;
   logic                     w_grant_sq;
   logic                     w_grant_cq;
   logic                     w_aw_done;
   logic                     w_w_done;
   logic                     w_cqe_ready;
   logic                     w_take;
   logic                     w_unused;

   assign w_sq_pend   = (sq_tail != r_rung_tail);
   assign w_aw_done   = ~r_awvalid | nl_awready;
   assign w_w_done    = ~r_wvalid | nl_wready;
   // Gated by rstn so the ready also reads 0 while the block is held in reset.
   assign w_cqe_ready = rstn & (~r_cpl_valid | cpl_ready);
   assign w_take      = cqe_valid & w_cqe_ready & (cqe_data[112] == r_exp_phase);
   assign w_unused    = ^{cqe_data[95:64+PW], cqe_data[63:0]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_sq  = 1'b0;
      w_grant_cq  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sq_pend && r_cq_pending) begin
               w_grant_sq = r_last_grant_cq;
               w_grant_cq = ~r_last_grant_cq;
            end else begin
               w_grant_sq = w_sq_pend;
               w_grant_cq = r_cq_pending;
            end
            if (w_grant_sq || w_grant_cq) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE:  if (w_aw_done && w_w_done) w_state_nxt = ST_WAIT_B;
         ST_WAIT_B: if (nl_bvalid) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rung_tail     <= '0;
         r_last_grant_cq <= 1'b1;
         r_awvalid       <= 1'b0;
         r_wvalid        <= 1'b0;
         r_awaddr        <= '0;
         r_wdata         <= '0;
         r_db_err        <= 1'b0;
      end else begin
         if (w_grant_sq) begin
            r_awaddr        <= SQ_ADDR;
            r_wdata         <= NL_DATA_WIDTH'(sq_tail);
            r_rung_tail     <= sq_tail;
            r_awvalid       <= 1'b1;
            r_wvalid        <= 1'b1;
            r_last_grant_cq <= 1'b0;
         end else if (w_grant_cq) begin
            r_awaddr        <= CQ_ADDR;
            r_wdata         <= NL_DATA_WIDTH'(r_cq_head);
            r_awvalid       <= 1'b1;
            r_wvalid        <= 1'b1;
            r_last_grant_cq <= 1'b1;
         end else begin
            // AW and W retire independently; address and data hold until both have.
            if (nl_awready) r_awvalid <= 1'b0;
            if (nl_wready)  r_wvalid  <= 1'b0;
         end
         if (r_state == ST_WAIT_B && nl_bvalid && nl_bresp != 2'b00) r_db_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cq_head    <= '0;
         r_sq_head    <= '0;
         r_exp_phase  <= 1'b1;
         r_cq_pending <= 1'b0;
         r_cpl_valid  <= 1'b0;
         r_cpl_cid    <= '0;
         r_cpl_status <= '0;
      end else begin
         if (w_take) begin
            r_cpl_valid  <= 1'b1;
            r_cpl_cid    <= cqe_data[111:96];
            r_cpl_status <= cqe_data[127:113];
            r_sq_head    <= cqe_data[64 +: PW];
            r_cq_head    <= r_cq_head + PW'(1);
            r_cq_pending <= 1'b1;
            if (r_cq_head == HEAD_LAST) r_exp_phase <= ~r_exp_phase;
         end else begin
            if (cpl_ready)  r_cpl_valid  <= 1'b0;
            if (w_grant_cq) r_cq_pending <= 1'b0;
         end
      end
   end

   assign cqe_ready  = w_cqe_ready;
   assign sq_head    = r_sq_head;
   assign cpl_valid  = r_cpl_valid;
   assign cpl_cid    = r_cpl_cid;
   assign cpl_status = r_cpl_status;
   assign nl_awaddr  = r_awaddr;
   assign nl_awvalid = r_awvalid;
   assign nl_wdata   = r_wdata;
   assign nl_wstrb   = '1;
   assign nl_wvalid  = r_wvalid;
   assign nl_bready  = (r_state == ST_WAIT_B);
   assign db_err     = r_db_err;

endmodule

// File: tb/tb_nvme_doorbell_cq_ctrl.sv
// Directed bench for nvme_doorbell_cq_ctrl: doorbell sequencing, CQE phase handling,
// round-robin arbitration, split AXI handshakes, backpressure and async reset.
module tb_nvme_doorbell_cq_ctrl;

   logic         clk;
   logic         rstn;
   logic [3:0]   sq_tail;
   logic         cqe_valid;
   logic         cqe_ready;
   logic [127:0] cqe_data;
   logic [3:0]   sq_head;
   logic         cpl_valid;
   logic         cpl_ready;
   logic [15:0]  cpl_cid;
   logic [14:0]  cpl_status;
   logic [31:0]  nl_awaddr;
   logic         nl_awvalid;
   logic         nl_awready;
   logic [31:0]  nl_wdata;
   logic [3:0]   nl_wstrb;
   logic         nl_wvalid;
   logic         nl_wready;
   logic [1:0]   nl_bresp;
   logic         nl_bvalid;
   logic         nl_bready;
   logic         db_err;

   int errors = 0;
   int checks = 0;

   nvme_doorbell_cq_ctrl dut (
      .clk(clk), .rstn(rstn), .sq_tail(sq_tail),
      .cqe_valid(cqe_valid), .cqe_ready(cqe_ready), .cqe_data(cqe_data),
      .sq_head(sq_head), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
      .cpl_cid(cpl_cid), .cpl_status(cpl_status),
      .nl_awaddr(nl_awaddr), .nl_awvalid(nl_awvalid), .nl_awready(nl_awready),
      .nl_wdata(nl_wdata), .nl_wstrb(nl_wstrb), .nl_wvalid(nl_wvalid),
      .nl_wready(nl_wready), .nl_bresp(nl_bresp), .nl_bvalid(nl_bvalid),
      .nl_bready(nl_bready), .db_err(db_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   function automatic logic [127:0] mk_cqe(input logic [15:0] cid, input logic [15:0] sqh,
                                            input logic ph, input logic [14:0] st);
      logic [127:0] d;
      d          = '0;
      d[31:0]    = 32'hDEAD_0000 | {16'h0, cid};
      d[79:64]   = sqh;
      d[111:96]  = cid;
      d[112]     = ph;
      d[127:113] = st;
      return d;
   endfunction

   task automatic apply_reset();
      rstn = 1'b0; sq_tail = '0; cqe_valid = 1'b0; cqe_data = '0; cpl_ready = 1'b0;
      nl_awready = 1'b0; nl_wready = 1'b0; nl_bvalid = 1'b0; nl_bresp = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic send_cqe(input logic [15:0] cid, input logic [15:0] sqh, input logic ph);
      cqe_valid = 1'b1; cqe_data = mk_cqe(cid, sqh, ph, 15'h0);
      @(negedge clk);
      cqe_valid = 1'b0;
   endtask

   task automatic axi_finish(input logic [1:0] resp);
      nl_awready = 1'b1; nl_wready = 1'b1;
      @(negedge clk);
      nl_awready = 1'b0; nl_wready = 1'b0; nl_bvalid = 1'b1; nl_bresp = resp;
      @(negedge clk);
      nl_bvalid = 1'b0; nl_bresp = 2'b00;
   endtask

   task automatic test_reset();
      rstn = 1'b0; sq_tail = '0; cqe_valid = 1'b0; cqe_data = '0; cpl_ready = 1'b0;
      nl_awready = 1'b0; nl_wready = 1'b0; nl_bvalid = 1'b0; nl_bresp = 2'b00;
      @(negedge clk);
      checks++; if (cqe_ready !== 1'b0) begin errors++; $display("FAIL rst_cqe_ready: got %b want 0", cqe_ready); end
      checks++; if (cpl_valid !== 1'b0) begin errors++; $display("FAIL rst_cpl_valid: got %b want 0", cpl_valid); end
      checks++; if (nl_awvalid !== 1'b0 || nl_wvalid !== 1'b0) begin errors++; $display("FAIL rst_valids: got aw=%b w=%b want 0", nl_awvalid, nl_wvalid); end
      checks++; if (nl_wstrb !== 4'hF) begin errors++; $display("FAIL rst_wstrb: got %h want f", nl_wstrb); end
      checks++; if (nl_bready !== 1'b0 || db_err !== 1'b0) begin errors++; $display("FAIL rst_bready_err: got %b/%b want 0/0", nl_bready, db_err); end
      checks++; if (nl_awaddr !== 32'h0 || nl_wdata !== 32'h0 || sq_head !== 4'h0) begin errors++; $display("FAIL rst_data: got addr=%h data=%h sqh=%h want 0", nl_awaddr, nl_wdata, sq_head); end
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (cqe_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cqe_ready: got %b want 1", cqe_ready); end
      checks++; if (nl_awvalid !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got awvalid=%b want 0", nl_awvalid); end
   endtask

   task automatic test_sq_doorbell();
      sq_tail = 4'd3;
      checks++; if (nl_awvalid !== 1'b0) begin errors++; $display("FAIL sq_early: got awvalid=%b want 0", nl_awvalid); end
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_wvalid !== 1'b1) begin errors++; $display("FAIL sq_valids: got aw=%b w=%b want 1/1", nl_awvalid, nl_wvalid); end
      checks++; if (nl_awaddr !== 32'h1000) begin errors++; $display("FAIL sq_addr: got %h want 00001000", nl_awaddr); end
      checks++; if (nl_wdata !== 32'd3) begin errors++; $display("FAIL sq_data: got %h want 3", nl_wdata); end
      checks++; if (nl_wstrb !== 4'hF) begin errors++; $display("FAIL sq_wstrb: got %h want f", nl_wstrb); end
      nl_awready = 1'b1; nl_wready = 1'b1;
      @(negedge clk);
      nl_awready = 1'b0; nl_wready = 1'b0;
      checks++; if (nl_awvalid !== 1'b0 || nl_wvalid !== 1'b0) begin errors++; $display("FAIL sq_drop: got aw=%b w=%b want 0/0", nl_awvalid, nl_wvalid); end
      checks++; if (nl_bready !== 1'b1) begin errors++; $display("FAIL sq_bready: got %b want 1", nl_bready); end
      nl_bvalid = 1'b1; nl_bresp = 2'b00;
      @(negedge clk);
      nl_bvalid = 1'b0;
      checks++; if (nl_bready !== 1'b0 || db_err !== 1'b0) begin errors++; $display("FAIL sq_done: got bready=%b err=%b want 0/0", nl_bready, db_err); end
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b0) begin errors++; $display("FAIL sq_no_rering: got awvalid=%b want 0", nl_awvalid); end
   endtask

   task automatic test_cqe();
      cqe_valid = 1'b1; cqe_data = mk_cqe(16'd5, 16'd4, 1'b1, 15'h0012);
      checks++; if (cqe_ready !== 1'b1) begin errors++; $display("FAIL cqe_ready: got %b want 1", cqe_ready); end
      @(negedge clk);
      cqe_valid = 1'b0;
      checks++; if (cpl_valid !== 1'b1) begin errors++; $display("FAIL cqe_cpl_valid: got %b want 1", cpl_valid); end
      checks++; if (cpl_cid !== 16'd5) begin errors++; $display("FAIL cqe_cid: got %h want 5", cpl_cid); end
      checks++; if (cpl_status !== 15'h0012) begin errors++; $display("FAIL cqe_status: got %h want 0012", cpl_status); end
      checks++; if (sq_head !== 4'd4) begin errors++; $display("FAIL cqe_sq_head: got %h want 4", sq_head); end
      cpl_ready = 1'b1;
      @(negedge clk);
      checks++; if (cpl_valid !== 1'b0) begin errors++; $display("FAIL cqe_cpl_clear: got %b want 0", cpl_valid); end
      checks++; if (nl_awvalid !== 1'b1 || nl_awaddr !== 32'h1004 || nl_wdata !== 32'd1) begin errors++; $display("FAIL cq_db: got v=%b addr=%h data=%h want 1/00001004/1", nl_awvalid, nl_awaddr, nl_wdata); end
      axi_finish(2'b00);
   endtask

   task automatic test_phase_wrap();
      apply_reset();
      cpl_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cqe_valid = 1'b1; cqe_data = mk_cqe(16'(i), 16'(i), 1'b1, 15'h0);
         @(negedge clk);
         checks++; if (cpl_valid !== 1'b1 || cpl_cid !== 16'(i)) begin errors++; $display("FAIL wrap_cpl[%0d]: got v=%b cid=%h want 1/%h", i, cpl_valid, cpl_cid, i); end
      end
      cqe_valid = 1'b1; cqe_data = mk_cqe(16'h0099, 16'd9, 1'b1, 15'h0);
      @(negedge clk);
      cqe_valid = 1'b0;
      checks++; if (cpl_valid !== 1'b0) begin errors++; $display("FAIL wrap_stale_dropped: got cpl_valid=%b want 0", cpl_valid); end
      checks++; if (sq_head !== 4'd15) begin errors++; $display("FAIL wrap_stale_sqh: got %h want f", sq_head); end
      checks++; if (nl_awvalid !== 1'b1 || nl_wdata !== 32'd1) begin errors++; $display("FAIL wrap_first_db: got v=%b data=%h want 1/1", nl_awvalid, nl_wdata); end
      axi_finish(2'b00);
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_awaddr !== 32'h1004 || nl_wdata !== 32'd0) begin errors++; $display("FAIL wrap_head_db: got v=%b addr=%h data=%h want 1/00001004/0", nl_awvalid, nl_awaddr, nl_wdata); end
      axi_finish(2'b00);
      cqe_valid = 1'b1; cqe_data = mk_cqe(16'h0077, 16'd2, 1'b0, 15'h0);
      @(negedge clk);
      cqe_valid = 1'b0;
      checks++; if (cpl_valid !== 1'b1 || cpl_cid !== 16'h0077 || sq_head !== 4'd2) begin errors++; $display("FAIL wrap_phase0: got v=%b cid=%h sqh=%h want 1/0077/2", cpl_valid, cpl_cid, sq_head); end
   endtask

   task automatic test_round_robin();
      apply_reset();
      cpl_ready = 1'b1;
      send_cqe(16'd1, 16'd0, 1'b1);
      sq_tail = 4'd1;
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_awaddr !== 32'h1000 || nl_wdata !== 32'd1) begin errors++; $display("FAIL rr_g0_sq: got v=%b addr=%h data=%h want 1/00001000/1", nl_awvalid, nl_awaddr, nl_wdata); end
      sq_tail = 4'd2;
      axi_finish(2'b00);
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_awaddr !== 32'h1004 || nl_wdata !== 32'd1) begin errors++; $display("FAIL rr_g1_cq: got v=%b addr=%h data=%h want 1/00001004/1", nl_awvalid, nl_awaddr, nl_wdata); end
      send_cqe(16'd2, 16'd0, 1'b1);
      axi_finish(2'b00);
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_awaddr !== 32'h1000 || nl_wdata !== 32'd2) begin errors++; $display("FAIL rr_g2_sq: got v=%b addr=%h data=%h want 1/00001000/2", nl_awvalid, nl_awaddr, nl_wdata); end
      sq_tail = 4'd3;
      axi_finish(2'b00);
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_awaddr !== 32'h1004 || nl_wdata !== 32'd2) begin errors++; $display("FAIL rr_g3_cq: got v=%b addr=%h data=%h want 1/00001004/2", nl_awvalid, nl_awaddr, nl_wdata); end
      axi_finish(2'b00);
   endtask

   task automatic test_split_handshake();
      apply_reset();
      sq_tail = 4'd5;
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_wvalid !== 1'b1) begin errors++; $display("FAIL split_start: got aw=%b w=%b want 1/1", nl_awvalid, nl_wvalid); end
      nl_wready = 1'b1;
      @(negedge clk);
      nl_wready = 1'b0;
      checks++; if (nl_wvalid !== 1'b0 || nl_awvalid !== 1'b1) begin errors++; $display("FAIL split_w_first: got aw=%b w=%b want 1/0", nl_awvalid, nl_wvalid); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_awaddr !== 32'h1000 || nl_wdata !== 32'd5 || nl_bready !== 1'b0) begin errors++; $display("FAIL split_aw_held: got v=%b addr=%h data=%h bready=%b want 1/00001000/5/0", nl_awvalid, nl_awaddr, nl_wdata, nl_bready); end
      nl_awready = 1'b1;
      @(negedge clk);
      nl_awready = 1'b0;
      checks++; if (nl_awvalid !== 1'b0 || nl_bready !== 1'b1) begin errors++; $display("FAIL split_aw_done: got aw=%b bready=%b want 0/1", nl_awvalid, nl_bready); end
      nl_bvalid = 1'b1; nl_bresp = 2'b10;
      @(negedge clk);
      nl_bvalid = 1'b0; nl_bresp = 2'b00;
      checks++; if (db_err !== 1'b1) begin errors++; $display("FAIL split_db_err: got %b want 1", db_err); end
      sq_tail = 4'd6;
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b1 || nl_wdata !== 32'd6) begin errors++; $display("FAIL split_next_db: got v=%b data=%h want 1/6", nl_awvalid, nl_wdata); end
      axi_finish(2'b00);
      @(negedge clk);
      checks++; if (db_err !== 1'b1) begin errors++; $display("FAIL split_err_sticky: got %b want 1", db_err); end
   endtask

   task automatic test_backpressure_reset();
      apply_reset();
      cqe_valid = 1'b1; cqe_data = mk_cqe(16'h0011, 16'd3, 1'b1, 15'h0);
      @(negedge clk);
      cqe_data = mk_cqe(16'h0022, 16'd7, 1'b1, 15'h0);
      checks++; if (cpl_valid !== 1'b1 || cpl_cid !== 16'h0011 || cqe_ready !== 1'b0) begin errors++; $display("FAIL bp_first: got v=%b cid=%h rdy=%b want 1/0011/0", cpl_valid, cpl_cid, cqe_ready); end
      @(negedge clk);
      checks++; if (cpl_cid !== 16'h0011 || sq_head !== 4'd3 || cqe_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got cid=%h sqh=%h rdy=%b want 0011/3/0", cpl_cid, sq_head, cqe_ready); end
      cpl_ready = 1'b1;
      #1;
      checks++; if (cqe_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got cqe_ready=%b want 1", cqe_ready); end
      @(negedge clk);
      checks++; if (cpl_valid !== 1'b1 || cpl_cid !== 16'h0022 || sq_head !== 4'd7) begin errors++; $display("FAIL bp_second: got v=%b cid=%h sqh=%h want 1/0022/7", cpl_valid, cpl_cid, sq_head); end
      cqe_data = mk_cqe(16'h0033, 16'd9, 1'b1, 15'h0);
      @(negedge clk);
      cqe_valid = 1'b0;
      checks++; if (cpl_valid !== 1'b1 || cpl_cid !== 16'h0033 || sq_head !== 4'd9) begin errors++; $display("FAIL bp_b2b: got v=%b cid=%h sqh=%h want 1/0033/9", cpl_valid, cpl_cid, sq_head); end
      @(negedge clk);
      checks++; if (cpl_valid !== 1'b0 || nl_awvalid !== 1'b1) begin errors++; $display("FAIL bp_drain: got cpl_v=%b awvalid=%b want 0/1", cpl_valid, nl_awvalid); end
      nl_awready = 1'b1; nl_wready = 1'b1;
      @(negedge clk);
      nl_awready = 1'b0; nl_wready = 1'b0;
      checks++; if (nl_bready !== 1'b1) begin errors++; $display("FAIL rst_mid_waitb: got bready=%b want 1", nl_bready); end
      #2;
      rstn = 1'b0;
      #1;
      checks++; if (nl_bready !== 1'b0 || nl_awvalid !== 1'b0 || nl_wvalid !== 1'b0 || cpl_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valids: got b=%b aw=%b w=%b cpl=%b want 0", nl_bready, nl_awvalid, nl_wvalid, cpl_valid); end
      checks++; if (nl_awaddr !== 32'h0 || nl_wdata !== 32'h0 || sq_head !== 4'h0 || cpl_cid !== 16'h0 || cqe_ready !== 1'b0 || nl_wstrb !== 4'hF) begin errors++; $display("FAIL async_rst_data: got addr=%h data=%h sqh=%h cid=%h rdy=%b strb=%h", nl_awaddr, nl_wdata, sq_head, cpl_cid, cqe_ready, nl_wstrb); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (nl_awvalid !== 1'b0 || nl_bready !== 1'b0) begin errors++; $display("FAIL post_async_idle: got aw=%b b=%b want 0/0", nl_awvalid, nl_bready); end
   endtask

   initial begin
      test_reset();
      test_sq_doorbell();
      test_cqe();
      test_phase_wrap();
      test_round_robin();
      test_split_handshake();
      test_backpressure_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nvme_doorbell_cq_ctrl.md
Name: nvme_doorbell_cq_ctrl

Overview:
- Sequences NVMe queue doorbells and consumes completion-queue entries for the host-write path.
- Watches the SQ tail published by the command-synthesis logic and rings the SQ tail doorbell over the AXI-Lite master (nl_*).
- Accepts 16-byte CQ entries captured from the NVMe-facing slave, tracks phase and CQ head, and exports the SQ head for queue-full gating.
- Arbitrates SQ-tail and CQ-head doorbell writes round-robin onto the single AXI-Lite write channel.

Parameters:
OUTSTANDING, 16, queue depth of both SQ and CQ; power of two
NL_ADDR_WIDTH, 32, AXI-Lite address width
NL_DATA_WIDTH, 32, AXI-Lite data width
SQ_DB_ADDR, 32'h0000_1000, SQ0 tail doorbell address
CQ_DB_ADDR, 32'h0000_1004, CQ0 head doorbell address

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
sq_tail  in  $clog2(OUTSTANDING)  current SQ tail from command synthesis
cqe_valid  in  1  CQ entry valid
cqe_ready  out  1  CQ entry accepted
cqe_data  in  128  CQ entry, DW0 at [31:0]
sq_head  out  $clog2(OUTSTANDING)  SQ head from latest accepted CQE
cpl_valid  out  1  completion valid
cpl_ready  in  1  completion accepted downstream
cpl_cid  out  16  command identifier, cqe_data[111:96]
cpl_status  out  15  status field, cqe_data[127:113]
nl_awaddr  out  NL_ADDR_WIDTH  doorbell address
nl_awvalid  out  1  AW valid
nl_awready  in  1  AW ready
nl_wdata  out  NL_DATA_WIDTH  doorbell value
nl_wstrb  out  NL_DATA_WIDTH/8  all ones
nl_wvalid  out  1  W valid
nl_wready  in  1  W ready
nl_bresp  in  2  write response
nl_bvalid  in  1  B valid
nl_bready  out  1  B ready
db_err  out  1  sticky: any bresp != 0

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous, active-low.
- Reset values: all outputs 0 except nl_wstrb, which is all ones. Internally: expected_phase=1, cq_head=0, rung_tail=0, cq_pending=0, last_grant=CQ, FSM=IDLE.
- Assertion of rstn mid-transaction drops all valids immediately and abandons any in-flight AXI-Lite write.
- Pending conditions: sq_pending = (sq_tail != rung_tail); cq_pending is set when a CQE is accepted.
- FSM IDLE:
  - If exactly one doorbell is pending, grant it.
  - If both are pending, grant the one not equal to last_grant.
  - On grant, register nl_awaddr and nl_wdata, assert nl_awvalid and nl_wvalid, update last_grant, and go to ISSUE. The doorbell is visible one cycle after pending is set.
  - SQ grant: wdata = zero-extended sq_tail; rung_tail <= sq_tail.
  - CQ grant: wdata = zero-extended cq_head at grant; clear cq_pending unless a CQE is accepted in the same cycle, in which case it stays set.
- FSM ISSUE:
  - Drop nl_awvalid after the AW handshake and nl_wvalid after the W handshake, independently. AW and W may complete in either order or in the same cycle.
  - Go to WAIT_B once both have completed. The AXI-Lite ordering rules apply: no valid is withdrawn before its handshake, and addr/data stay stable while valid.
- FSM WAIT_B: nl_bready=1. On nl_bvalid, go to IDLE and set db_err if nl_bresp != 0. The next grant can occur in the cycle after IDLE is re-entered.
- sq_tail changing while an SQ doorbell is in flight leaves sq_pending set afterwards, so the newer tail is rung next.
- CQE intake:
  - cqe_ready = ~cpl_valid | cpl_ready (single-entry output register).
  - An accepted entry whose phase bit cqe_data[112] != expected_phase is stale: it is consumed and discarded with no state change.
  - A valid-phase entry:
    - cpl_valid is asserted next cycle with cpl_cid and cpl_status.
    - sq_head <= cqe_data[79:64] modulo OUTSTANDING.
    - cq_head <= (cq_head+1) mod OUTSTANDING.
    - expected_phase toggles when cq_head wraps from OUTSTANDING-1 to 0.
- cpl_valid clears on cpl_ready unless a new valid entry is accepted in the same cycle.
- Throughput: one CQE per cycle with cpl_ready held high.
- Width rules: all head/tail arithmetic is modulo OUTSTANDING; doorbell values are zero-extended to NL_DATA_WIDTH.

Test Plan:
- Reset, then sq_tail 0->3 → one AXI-Lite write: addr 0x1000, data 3, wstrb 4'hF; awvalid rises one cycle after the change; db_err stays 0.
- CQE with cid=5, sq_head field=4, phase=1 → cpl_cid=5 and sq_head=4 next cycle; CQ doorbell write addr 0x1004, data 1.
- 16 valid CQEs with phase=1, then one with phase=1 again → the 17th is dropped (expected_phase is now 0); cq_head=0 and no cpl for it. A following phase=0 entry is accepted.
- SQ and CQ pending simultaneously, twice in succession → grants alternate SQ, CQ, SQ, CQ.
- nl_wready asserted 3 cycles before nl_awready → wvalid drops first, awvalid held; nl_bresp=2'b10 → db_err=1 and remains set.
- cpl_ready held low with 2 CQEs offered → first presented, cqe_ready=0 and second stalled; raising cpl_ready → back-to-back acceptance. rstn pulsed during WAIT_B → outputs return to 0 asynchronously.
